// File: rtl/bm_awgn.sv
// Box-Muller Gaussian noise source: two xorshift32 uniforms per cycle in, one
// Q5.11 (cos, sin) sample pair out per cycle behind a five-register pipeline.
module bm_awgn_lane (
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic [18:0] f,
  input  logic [31:0] trig,
  output logic [15:0] x
);
  logic signed [51:0] prod = '0;
  logic signed [15:0] xr   = '0;
  logic signed [51:0] fe, te, rnd;

  assign fe  = {33'd0, f};
  assign te  = {{20{trig[31]}}, trig};
  // Q3.16 * Q1.30 -> Q.46; round half-up into Q.11
  assign rnd = (prod + 52'sd17179869184) >>> 35;
  assign x   = xr;

  always_ff @(posedge clk) begin
    if (clear) begin
      prod <= '0;
      xr   <= '0;
    end else begin
      prod <= fe * te;
      if (!en)                    xr <= '0;
      else if (rnd > 52'sd32767)  xr <= 16'sh7fff;
      else if (rnd < -52'sd32768) xr <= 16'sh8000;
      else                        xr <= rnd[15:0];
    end
  end
endmodule

module bm_awgn (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        seed1,
  input  logic [31:0]        seed2,
  output logic               v,
  output logic signed [15:0] x0,
  output logic signed [15:0] x1
);
  localparam int          STAGES = 4;
  localparam logic [31:0] ZSUB   = 32'h2545F491;
  localparam logic [63:0] ONE    = 64'd1 << 30;
  localparam logic [63:0] PI_Q30 = 64'd3373259426;  // pi * 2^30
  localparam logic [63:0] LN2X2  = 64'd2977044472;  // 2*ln2 * 2^31

  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  // -log2(m/65536) in Q5.20: exponent from the leading one, fraction by
  // repeated squaring of the normalised mantissa.
  function automatic logic [24:0] neglog2(input logic [16:0] m);
    logic [4:0]  e;
    logic [31:0] x;
    logic [63:0] sq;
    logic [19:0] fr;
    e = '0;
    for (int i = 0; i < 17; i++) if (m[i]) e = 5'(i);
    x  = {15'd0, m} << (31 - e);
    fr = '0;
    for (int i = 19; i >= 0; i--) begin
      sq = 64'(x) * 64'(x);
      if (sq[63]) begin
        fr[i] = 1'b1;
        x     = sq[63:32];
      end else begin
        x     = sq[62:31];
      end
    end
    return {5'd16 - e, 20'd0} - {5'd0, fr};
  endfunction

  // Octant-folded Taylor series; returns {sin, cos} as signed Q1.30.
  function automatic logic [63:0] sincos(input logic [15:0] p);
    logic [1:0]         q;
    logic [13:0]        r;
    logic [14:0]        rr;
    logic [63:0]        t, t2, a, b, c, sn, cs;
    logic signed [31:0] s0, c0, co, si;
    q  = p[15:14];
    r  = p[13:0];
    rr = r[13] ? (15'd16384 - {1'b0, r}) : {1'b0, r};
    t  = (64'(rr) * PI_Q30) >> 15;
    t2 = (t * t) >> 30;
    a  = ONE - t2 / 42;
    b  = ONE - ((t2 * a) >> 30) / 20;
    c  = ONE - ((t2 * b) >> 30) / 6;
    sn = (t * c) >> 30;
    a  = ONE - t2 / 56;
    b  = ONE - ((t2 * a) >> 30) / 30;
    c  = ONE - ((t2 * b) >> 30) / 12;
    cs = ONE - ((t2 * c) >> 30) / 2;
    s0 = r[13] ? signed'(cs[31:0]) : signed'(sn[31:0]);
    c0 = r[13] ? signed'(sn[31:0]) : signed'(cs[31:0]);
    case (q)
      2'd0:    begin co = c0;  si = s0;  end
      2'd1:    begin co = -s0; si = c0;  end
      2'd2:    begin co = -c0; si = -s0; end
      default: begin co = s0;  si = -c0; end
    endcase
    return {si, co};
  endfunction

  function automatic logic [18:0] isqrt(input logic [37:0] z);
    logic [18:0] root, cand;
    logic [37:0] sq;
    root = '0;
    for (int i = 18; i >= 0; i--) begin
      cand = root | (19'd1 << i);
      sq   = 38'(cand) * 38'(cand);
      if (sq <= z) root = cand;
    end
    return root;
  endfunction

  logic              loaded = 1'b0;
  logic [31:0]       sa = '0, sb = '0;
  logic [STAGES:0]   vld_pipe = '0;
  logic [16:0]       m1 = '0;
  logic [15:0]       p1 = '0;
  logic [24:0]       y2 = '0;
  logic [1:0][31:0]  tr2 = '0, tr3 = '0;
  logic [18:0]       f3 = '0;
  logic              load;
  logic [31:0]       na, nb;
  logic [24:0]       y_c;
  logic [63:0]       tr_c;
  logic [63:0]       z_c;
  logic [18:0]       f_c;
  logic [1:0][15:0]  xl;

  assign load = reset | ~loaded;
  assign na   = xs32(sa);
  assign nb   = xs32(sb);
  assign y_c  = neglog2(m1);
  assign tr_c = sincos(p1);
  assign z_c  = (64'(y2) * LN2X2) >> 19;  // -2ln(u0) in Q.32
  assign f_c  = isqrt(z_c[37:0]);

  always_ff @(posedge clk) begin
    if (load) begin
      loaded   <= 1'b1;
      sa       <= (seed1 == '0) ? ZSUB : seed1;
      sb       <= (seed2 == '0) ? ZSUB : seed2;
      vld_pipe <= '0;
      m1       <= '0;
      p1       <= '0;
      y2       <= '0;
      tr2      <= '0;
      tr3      <= '0;
      f3       <= '0;
    end else begin
      sa       <= na;
      sb       <= nb;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      m1       <= {1'b0, na[31:16]} + 17'd1;
      p1       <= nb[31:16];
      y2       <= y_c;
      tr2      <= tr_c;
      f3       <= f_c;
      tr3      <= tr2;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    bm_awgn_lane u_lane (
      .clk  (clk),
      .clear(load),
      .en   (vld_pipe[STAGES-1]),
      .f    (f3),
      .trig (tr3[g]),
      .x    (xl[g])
    );
  end

  assign v  = vld_pipe[STAGES];
  assign x0 = xl[0];
  assign x1 = xl[1];
endmodule

// File: tb/tb_bm_awgn.sv
// Bench for bm_awgn: xorshift + real-valued Box-Muller reference, reset replay,
// seed substitution, extreme-uniform cases and output statistics.
module tb_bm_awgn;
  localparam real         PI   = 3.14159265358979323846;
  localparam int unsigned S1   = 32'h67580;
  localparam int unsigned S2   = 32'h70385;
  localparam int          NREC = 300;
  localparam int          NSTAT = 40000;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [31:0]        seed1 = S1;
  logic [31:0]        seed2 = S2;
  logic               v;
  logic signed [15:0] x0, x1;

  int checks = 0;
  int errors = 0;
  int unsigned ma, mb;
  logic signed [15:0] rec0 [NREC];
  logic signed [15:0] rec1 [NREC];

  always #5 clk = ~clk;

  bm_awgn dut (
    .clk  (clk),
    .reset(reset),
    .seed1(seed1),
    .seed2(seed2),
    .v    (v),
    .x0   (x0),
    .x1   (x1)
  );

  function automatic int unsigned xs(input int unsigned s);
    s = s ^ (s << 13);
    s = s ^ (s >> 17);
    return s ^ (s << 5);
  endfunction

  function automatic int unsigned xs_inv(input int unsigned y);
    int unsigned x;
    x = y; for (int i = 0; i < 7; i++) x = y ^ (x << 5);
    y = x; for (int i = 0; i < 2; i++) x = y ^ (x >> 17);
    y = x; for (int i = 0; i < 3; i++) x = y ^ (x << 13);
    return x;
  endfunction

  function automatic int unsigned subst(input int unsigned s);
    return (s == 0) ? 32'h2545F491 : s;
  endfunction

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  // Real-valued Box-Muller on the top halves of the two post-update states.
  task automatic gold(input int unsigned a, input int unsigned b, output real g0, output real g1);
    real u0, u1, f;
    u0 = real'((a >> 16) + 1) / 65536.0;
    u1 = real'(b >> 16) / 65536.0;
    f  = $sqrt(rabs(-2.0 * $ln(u0)));
    g0 = f * $cos(2.0 * PI * u1) * 2048.0;
    g1 = f * $sin(2.0 * PI * u1) * 2048.0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One load edge followed by the four fill edges; the next tick yields sample 1.
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({v, x0, x1} !== 33'd0) begin
      errors++;
      $display("FAIL powerup_t0 got v=%b x0=%0d x1=%0d exp all 0", v, x0, x1);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if ({v, x0, x1} !== 33'd0) begin
        errors++;
        $display("FAIL powerup_edge%0d got v=%b x0=%0d x1=%0d exp all 0", k, v, x0, x1);
      end
    end
  endtask

  task automatic test_stream();
    real g0, g1;
    ma = subst(S1);
    mb = subst(S2);
    for (int n = 0; n < NREC; n++) begin
      if (n == 100) begin
        seed1 = $urandom;
        seed2 = $urandom;
      end
      tick();
      ma = xs(ma);
      mb = xs(mb);
      gold(ma, mb, g0, g1);
      rec0[n] = x0;
      rec1[n] = x1;
      checks++;
      if (v !== 1'b1) begin
        errors++;
        $display("FAIL stream_v n=%0d got=%b exp=1", n, v);
      end
      checks++;
      if (rabs(real'(x0) - g0) > 8.0) begin
        errors++;
        $display("FAIL stream_x0 n=%0d got=%0d exp=%f", n, x0, g0);
      end
      checks++;
      if (rabs(real'(x1) - g1) > 8.0) begin
        errors++;
        $display("FAIL stream_x1 n=%0d got=%0d exp=%f", n, x1, g1);
      end
    end
  endtask

  task automatic test_reset_replay();
    seed1 = S1;
    seed2 = S2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({v, x0, x1} !== 33'd0) begin
      errors++;
      $display("FAIL replay_after_reset got v=%b x0=%0d x1=%0d exp all 0", v, x0, x1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (v !== 1'b0) begin
        errors++;
        $display("FAIL replay_fill k=%0d got v=%b exp=0", k, v);
      end
    end
    for (int n = 0; n < NREC; n++) begin
      tick();
      checks++;
      if (v !== 1'b1 || x0 !== rec0[n] || x1 !== rec1[n]) begin
        errors++;
        $display("FAIL replay n=%0d got v=%b x0=%0d x1=%0d exp v=1 x0=%0d x1=%0d",
                 n, v, x0, x1, rec0[n], rec1[n]);
      end
    end
  endtask

  task automatic test_zero_seed();
    real g0, g1;
    int changes;
    logic signed [15:0] prev;
    seed1 = 32'd0;
    seed2 = $urandom | 32'd1;
    pulse_reset();
    ma = 32'h2545F491;
    mb = seed2;
    changes = 0;
    prev = 16'sd0;
    for (int n = 0; n < 200; n++) begin
      tick();
      ma = xs(ma);
      mb = xs(mb);
      gold(ma, mb, g0, g1);
      if (n > 0 && x0 != prev) changes++;
      prev = x0;
      checks++;
      if (rabs(real'(x0) - g0) > 8.0 || rabs(real'(x1) - g1) > 8.0 || v !== 1'b1) begin
        errors++;
        $display("FAIL zero_seed n=%0d got v=%b x0=%0d x1=%0d exp x0=%f x1=%f",
                 n, v, x0, x1, g0, g1);
      end
    end
    checks++;
    if (changes == 0) begin
      errors++;
      $display("FAIL zero_seed_nonconst got changes=0 exp >0");
    end
  endtask

  task automatic test_extremes();
    int unsigned r;
    // u0 = 1: post-update A has top half 0xFFFF
    r = $urandom;
    seed1 = xs_inv({16'hFFFF, r[15:0] | 16'd1});
    seed2 = xs_inv($urandom | 32'd1);
    pulse_reset();
    tick();
    checks++;
    if (v !== 1'b1 || rabs(real'(x0)) > 8.0 || rabs(real'(x1)) > 8.0) begin
      errors++;
      $display("FAIL extreme_u0_one got v=%b x0=%0d x1=%0d exp v=1 x0=0 x1=0 (+-8)", v, x0, x1);
    end
    // u0 = 1/65536, u1 = 0
    r = $urandom;
    seed1 = xs_inv({16'h0000, r[15:0] | 16'd1});
    seed2 = xs_inv({16'h0000, r[31:16] | 16'd1});
    pulse_reset();
    tick();
    checks++;
    if (v !== 1'b1 || rabs(real'(x0) - 9646.0) > 8.0 || rabs(real'(x1)) > 8.0) begin
      errors++;
      $display("FAIL extreme_u0_min got v=%b x0=%0d x1=%0d exp v=1 x0=9646 x1=0 (+-8)", v, x0, x1);
    end
  endtask

  task automatic test_stats();
    real s0, s1, q0, q1, m0, m1, var0, var1;
    int mx0, mx1, vlow, a0, a1;
    seed1 = $urandom | 32'd1;
    seed2 = $urandom | 32'd1;
    pulse_reset();
    s0 = 0.0; s1 = 0.0; q0 = 0.0; q1 = 0.0;
    mx0 = 0; mx1 = 0; vlow = 0;
    for (int n = 0; n < NSTAT; n++) begin
      tick();
      if (v !== 1'b1) vlow++;
      s0 += real'(x0) / 2048.0;
      s1 += real'(x1) / 2048.0;
      q0 += (real'(x0) / 2048.0) ** 2;
      q1 += (real'(x1) / 2048.0) ** 2;
      a0 = (x0 < 0) ? -int'(x0) : int'(x0);
      a1 = (x1 < 0) ? -int'(x1) : int'(x1);
      if (a0 > mx0) mx0 = a0;
      if (a1 > mx1) mx1 = a1;
    end
    m0 = s0 / NSTAT;
    m1 = s1 / NSTAT;
    var0 = q0 / NSTAT - m0 * m0;
    var1 = q1 / NSTAT - m1 * m1;
    checks++;
    if (vlow != 0) begin errors++; $display("FAIL stats_v_low got=%0d exp=0", vlow); end
    checks++;
    if (rabs(m0) >= 0.02) begin errors++; $display("FAIL stats_mean_x0 got=%f exp |m|<0.02", m0); end
    checks++;
    if (rabs(m1) >= 0.02) begin errors++; $display("FAIL stats_mean_x1 got=%f exp |m|<0.02", m1); end
    checks++;
    if (rabs(var0 - 1.0) > 0.03) begin errors++; $display("FAIL stats_var_x0 got=%f exp 1.0+-0.03", var0); end
    checks++;
    if (rabs(var1 - 1.0) > 0.03) begin errors++; $display("FAIL stats_var_x1 got=%f exp 1.0+-0.03", var1); end
    checks++;
    if (mx0 > 9667) begin errors++; $display("FAIL stats_max_x0 got=%0d exp <=9667", mx0); end
    checks++;
    if (mx1 > 9667) begin errors++; $display("FAIL stats_max_x1 got=%0d exp <=9667", mx1); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reset_replay();
    test_zero_seed();
    test_extremes();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
